// File: rtl/game_pkg.sv
// Shared constants and types for the brick-game video path.
// Latency: n/a (package only).
// Backpressure: n/a.
package game_pkg;

  // Horizontal raster, 800x600@72 Hz on a 50 MHz pixel clock
  localparam int H_VISIBLE    = 800;
  localparam int H_FRONT      = 56;
  localparam int H_SYNC       = 120;
  localparam int H_BACK       = 64;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;   // 1040
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;                     // 856
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;               // 975

  // Vertical raster
  localparam int V_VISIBLE    = 600;
  localparam int V_FRONT      = 37;
  localparam int V_SYNC       = 6;
  localparam int V_BACK       = 23;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;   // 666
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;                     // 637
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;               // 642

  // Brick grid geometry (also used by brick_finder)
  localparam int BRICK_W   = 100;
  localparam int BRICK_H   = 30;
  localparam int GRID_X0   = 0;
  localparam int GRID_Y0   = 0;
  localparam int GRID_COLS = 8;
  localparam int GRID_ROWS = 8;

  // Paddle and score-bar bands
  localparam int PADDLE_Y_TOP = 571;
  localparam int PADDLE_Y_BOT = 578;
  localparam int SCORE_Y_TOP  = 590;
  localparam int SCORE_Y_BOT  = 599;
  localparam int SCORE_STEP   = 6;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam rgb332_t COL_BLACK  = '{r: 3'b000, g: 3'b000, b: 2'b00};
  localparam rgb332_t COL_WHITE  = '{r: 3'b111, g: 3'b111, b: 2'b11};
  localparam rgb332_t COL_CYAN   = '{r: 3'b000, g: 3'b111, b: 2'b11};
  localparam rgb332_t COL_GREEN  = '{r: 3'b000, g: 3'b111, b: 2'b00};
  localparam rgb332_t COL_RED    = '{r: 3'b111, g: 3'b000, b: 2'b00};
  localparam rgb332_t COL_ORANGE = '{r: 3'b111, g: 3'b100, b: 2'b00};
  localparam rgb332_t COL_YELLOW = '{r: 3'b111, g: 3'b111, b: 2'b00};

endpackage

// File: rtl/game_render_vga_timing.sv
// Free-running VGA raster counters with raw sync and visible-area decode.
// Latency: flags are combinational from the counters (0 cycles).
// Backpressure: none; the raster advances every clock.
module vga_timing
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        visible,
  output logic        hsync_raw,
  output logic        vsync_raw
);

  // Raster scan: h wraps every line, v steps when h wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 11'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Decode the display window and the active-high sync pulses.
  always_comb begin
    visible   = (h_cnt < 11'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    hsync_raw = (h_cnt >= 11'(H_SYNC_START)) && (h_cnt <= 11'(H_SYNC_END));
    vsync_raw = (v_cnt >= 10'(V_SYNC_START)) && (v_cnt <= 10'(V_SYNC_END));
  end

endmodule

// File: rtl/game_render.sv
// Brick-game video output: per-frame input snapshot, object hit tests, 3-3-2 RGB.
// Latency: 2 cycles from raster counter to RGB/sync (region stage, colour stage).
// Backpressure: none; free-running pixel stream, inputs sampled once per frame.
module game_render
  import game_pkg::*;
#(
  parameter int RADIUS        = 4,
  parameter int PADDLE_LENGTH = 60
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [63:0][1:0] brick,
  input  logic [10:0]     ball_x,
  input  logic [9:0]      ball_y,
  input  logic [10:0]     paddle_x,
  input  logic [6:0]      score,
  output logic            hsync,
  output logic            vsync,
  output logic [2:0]      vga_r,
  output logic [2:0]      vga_g,
  output logic [1:0]      vga_b,
  output logic            frame_tick
);

  localparam logic signed [11:0] RAD   = 12'(RADIUS);
  localparam logic signed [11:0] PLEN  = 12'(PADDLE_LENGTH);
  localparam logic signed [11:0] X_MAX = 12'(H_VISIBLE - 1);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        visible, hsync_raw, vsync_raw;

  vga_timing u_timing (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  // Shadow copy of the game state; rendering never looks at the live inputs.
  logic [63:0][1:0] sh_brick;
  logic [10:0]      sh_ball_x, sh_paddle_x;
  logic [9:0]       sh_ball_y;
  logic [6:0]       sh_score;
  logic             snap;

  // The snapshot point is the first blanked line, so a frame is never torn.
  assign snap = (h_cnt == 11'd0) && (v_cnt == 10'(V_VISIBLE));

  // Load the shadow registers once per frame and flag it to the game core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_brick    <= '0;
      sh_ball_x   <= '0;
      sh_ball_y   <= '0;
      sh_paddle_x <= '0;
      sh_score    <= '0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= snap;
      if (snap) begin
        sh_brick    <= brick;
        sh_ball_x   <= ball_x;
        sh_ball_y   <= ball_y;
        sh_paddle_x <= paddle_x;
        sh_score    <= score;
      end
    end
  end

  // Region tests for the current raster position.
  logic [10:0] gx, x_base;
  logic [9:0]  gy, y_base;
  logic [2:0]  col, row;
  logic [6:0]  x_off;
  logic [4:0]  y_off;
  logic        in_grid, gap;
  logic [1:0]  level;
  logic signed [11:0] hx_s, vy_s, dx, dy, pad_l, pad_r;
  logic [10:0] score_lim;
  logic        ball_hit, paddle_hit, score_hit, brick_hit;

  // Grid cell found by a comparator chain against constant cell edges.
  always_comb begin
    gx     = h_cnt - 11'(GRID_X0);
    gy     = v_cnt - 10'(GRID_Y0);
    col    = '0;
    x_base = '0;
    row    = '0;
    y_base = '0;
    for (int i = 1; i < GRID_COLS; i++) begin
      if (gx >= 11'(i * BRICK_W)) begin
        col    = 3'(i);
        x_base = 11'(i * BRICK_W);
      end
    end
    for (int j = 1; j < GRID_ROWS; j++) begin
      if (gy >= 10'(j * BRICK_H)) begin
        row    = 3'(j);
        y_base = 10'(j * BRICK_H);
      end
    end
    x_off   = 7'(gx - x_base);
    y_off   = 5'(gy - y_base);
    in_grid = (gx < 11'(GRID_COLS * BRICK_W)) && (gy < 10'(GRID_ROWS * BRICK_H));
    gap     = (x_off == 7'd0) || (x_off == 7'(BRICK_W - 1)) ||
              (y_off == 5'd0) || (y_off == 5'(BRICK_H - 1));
    level     = sh_brick[{row, col}];
    brick_hit = in_grid && !gap && (level != 2'd0);
  end

  // Ball, paddle and score tests in signed 12-bit so edges near 0 do not wrap.
  always_comb begin
    hx_s  = $signed({1'b0, h_cnt});
    vy_s  = $signed({2'b00, v_cnt});
    dx    = hx_s - $signed({1'b0, sh_ball_x});
    dy    = vy_s - $signed({2'b00, sh_ball_y});
    ball_hit = (dx >= -RAD) && (dx <= RAD) && (dy >= -RAD) && (dy <= RAD);
    pad_l = $signed({1'b0, sh_paddle_x}) - PLEN;
    pad_r = $signed({1'b0, sh_paddle_x}) + PLEN;
    if (pad_l < 12'sd0) pad_l = 12'sd0;
    if (pad_r > X_MAX)  pad_r = X_MAX;
    paddle_hit = (v_cnt >= 10'(PADDLE_Y_TOP)) && (v_cnt <= 10'(PADDLE_Y_BOT)) &&
                 (hx_s >= pad_l) && (hx_s <= pad_r);
    score_lim  = 11'(sh_score) * 11'(SCORE_STEP);
    score_hit  = (v_cnt >= 10'(SCORE_Y_TOP)) && (v_cnt <= 10'(SCORE_Y_BOT)) &&
                 (h_cnt < score_lim);
  end

  // Stage A: register region flags, brick level and raw syncs.
  logic       vis_a, ball_a, paddle_a, score_a, brick_a, hs_a, vs_a;
  logic [1:0] level_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vis_a    <= 1'b0;
      ball_a   <= 1'b0;
      paddle_a <= 1'b0;
      score_a  <= 1'b0;
      brick_a  <= 1'b0;
      level_a  <= '0;
      hs_a     <= 1'b0;
      vs_a     <= 1'b0;
    end else begin
      vis_a    <= visible;
      ball_a   <= ball_hit;
      paddle_a <= paddle_hit;
      score_a  <= score_hit;
      brick_a  <= brick_hit;
      level_a  <= level;
      hs_a     <= hsync_raw;
      vs_a     <= vsync_raw;
    end
  end

  // Colour priority: ball, paddle, score bar, brick; blanking forces black.
  rgb332_t pix_nxt, pix_b;

  always_comb begin
    pix_nxt = COL_BLACK;
    if (vis_a) begin
      if (ball_a)        pix_nxt = COL_WHITE;
      else if (paddle_a) pix_nxt = COL_CYAN;
      else if (score_a)  pix_nxt = COL_GREEN;
      else if (brick_a) begin
        case (level_a)
          2'd3:    pix_nxt = COL_RED;
          2'd2:    pix_nxt = COL_ORANGE;
          2'd1:    pix_nxt = COL_YELLOW;
          default: pix_nxt = COL_BLACK;
        endcase
      end
    end
  end

  // Stage B: register the pixel and keep syncs aligned with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_b <= COL_BLACK;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      pix_b <= pix_nxt;
      hsync <= hs_a;
      vsync <= vs_a;
    end
  end

  assign vga_r = pix_b.r;
  assign vga_g = pix_b.g;
  assign vga_b = pix_b.b;

endmodule

// File: tb/tb_game_render.sv
// Bench for game_render: reference raster model, table of spot pixels, timing measurements.
// Latency: outputs expected 2 cycles after the matching counter cycle.
// Backpressure: n/a.
module tb_game_render;

  localparam int RADIUS = 4;
  localparam int PLEN   = 60;
  localparam int LINE   = 1040;
  localparam int LINES  = 666;
  localparam int FRAME  = LINE * LINES;
  localparam int SNAP   = 600 * LINE;

  localparam logic [7:0] C_BLACK  = 8'b000_000_00;
  localparam logic [7:0] C_WHITE  = 8'b111_111_11;
  localparam logic [7:0] C_CYAN   = 8'b000_111_11;
  localparam logic [7:0] C_GREEN  = 8'b000_111_00;
  localparam logic [7:0] C_RED    = 8'b111_000_00;
  localparam logic [7:0] C_ORANGE = 8'b111_100_00;
  localparam logic [7:0] C_YELLOW = 8'b111_111_00;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [63:0][1:0] brick;
  logic [10:0]      ball_x;
  logic [9:0]       ball_y;
  logic [10:0]      paddle_x;
  logic [6:0]       score;
  logic             hsync, vsync, frame_tick;
  logic [2:0]       vga_r, vga_g;
  logic [1:0]       vga_b;

  game_render #(.RADIUS(RADIUS), .PADDLE_LENGTH(PLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .brick      (brick),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_x   (paddle_x),
    .score      (score),
    .hsync      (hsync),
    .vsync      (vsync),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .frame_tick (frame_tick)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the display should be showing this frame.
  int m_brick[64];
  int m_bx, m_by, m_px, m_score;

  // Spot-pixel table (frame index counted from the last reset release).
  typedef struct {
    int         frame;
    int         x;
    int         y;
    logic [7:0] rgb;
    string      name;
  } vec_t;
  vec_t vecs[$];

  int   k, phase;
  int   line_err, bad_k;
  logic [10:0] bad_act, bad_exp;
  logic prev_hs, prev_vs, prev_ft;
  int   last_hrise, vrise, last_vrise, last_ft, n_hl, n_hw, hcount;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  // Expected colour of visible pixel (x,y) from the game rules.
  function automatic logic [7:0] model_pix(int x, int y);
    int lo, hi, lvl;
    if (x >= 800 || y >= 600) return C_BLACK;
    if (iabs(x - m_bx) <= RADIUS && iabs(y - m_by) <= RADIUS) return C_WHITE;
    lo = (m_px - PLEN < 0) ? 0 : m_px - PLEN;
    hi = (m_px + PLEN > 799) ? 799 : m_px + PLEN;
    if (y >= 571 && y <= 578 && x >= lo && x <= hi) return C_CYAN;
    if (y >= 590 && x < m_score * 6) return C_GREEN;
    if (y < 240 && (x % 100) != 0 && (x % 100) != 99 && (y % 30) != 0 && (y % 30) != 29) begin
      lvl = m_brick[(y / 30) * 8 + x / 100];
      if (lvl == 3) return C_RED;
      if (lvl == 2) return C_ORANGE;
      if (lvl == 1) return C_YELLOW;
    end
    return C_BLACK;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) m_brick[i] = 0;
    m_bx = 0; m_by = 0; m_px = 0; m_score = 0;
  endtask

  task automatic load_model();
    for (int i = 0; i < 64; i++) m_brick[i] = int'(brick[i]);
    m_bx = int'(ball_x); m_by = int'(ball_y); m_px = int'(paddle_x); m_score = int'(score);
  endtask

  task automatic drive_test_a();
    brick     = '0;
    brick[0]  = 2'd3;
    brick[9]  = 2'd3;
    brick[10] = 2'd1;
    ball_x    = 11'd2;
    ball_y    = 10'd575;
    paddle_x  = 11'd30;
    score     = 7'd10;
  endtask

  task automatic drive_random();
    for (int i = 0; i < 64; i++) brick[i] = 2'($urandom_range(0, 3));
    brick[0] = 2'd0;
    ball_x   = 11'($urandom_range(0, 799));
    ball_y   = 10'($urandom_range(100, 599));
    paddle_x = 11'($urandom_range(0, 799));
    score    = 7'($urandom_range(0, 127));
  endtask

  task automatic begin_phase();
    k = 0; line_err = 0; bad_k = 0; bad_act = '0; bad_exp = '0;
    prev_hs = 1'b0; prev_vs = 1'b0; prev_ft = 1'b0;
    last_hrise = -1; vrise = -1; last_vrise = -1; last_ft = -1;
    n_hl = 0; n_hw = 0; hcount = 0;
    clear_model();
  endtask

  // One clock of checking at the negedge of cycle k, then advance.
  task automatic step();
    int pk, ph, pv, pf;
    logic [7:0] act, exp_rgb;
    logic exp_hs, exp_vs, exp_ft;
    if (k >= 1 && ((k - 1) % FRAME) == SNAP) load_model();
    pk = k - 2; ph = -1; pv = 0; pf = 0;
    exp_rgb = C_BLACK; exp_hs = 1'b0; exp_vs = 1'b0;
    if (pk >= 0) begin
      ph = pk % LINE; pv = (pk / LINE) % LINES; pf = pk / FRAME;
      exp_rgb = model_pix(ph, pv);
      exp_hs  = (ph >= 856 && ph <= 975);
      exp_vs  = (pv >= 637 && pv <= 642);
    end
    exp_ft = (k >= 1) && (((k - 1) % FRAME) == SNAP);
    act = {vga_r, vga_g, vga_b};
    if (act !== exp_rgb || hsync !== exp_hs || vsync !== exp_vs || frame_tick !== exp_ft) begin
      if (line_err == 0) begin
        bad_k = k;
        bad_act = {act, hsync, vsync, frame_tick};
        bad_exp = {exp_rgb, exp_hs, exp_vs, exp_ft};
      end
      line_err++;
    end
    if (ph == LINE - 1) begin
      checks++;
      if (line_err != 0) begin
        failures++;
        $display("FAIL line_model phase=%0d frame=%0d line=%0d: %0d bad cycles, first at k=%0d got {rgb,hs,vs,ft}=%h expected %h",
                 phase, pf, pv, line_err, bad_k, bad_act, bad_exp);
      end
      line_err = 0;
    end
    if (phase == 1 && pk >= 0 && ph < 900) begin
      foreach (vecs[i])
        if (vecs[i].frame == pf && vecs[i].x == ph && vecs[i].y == pv)
          check(vecs[i].name, int'(act), int'(vecs[i].rgb));
    end
    // Raster timing measured directly from the sync edges.
    if (hsync && !prev_hs) begin
      if (last_hrise < 0) check("first_hsync_rise_clock", k, 856 + 2);
      else if (n_hl < 4) begin check("line_period_clocks", k - last_hrise, LINE); n_hl++; end
      last_hrise = k;
      hcount++;
    end
    if (!hsync && prev_hs && n_hw < 4) begin
      check("hsync_high_clocks", k - last_hrise, 120);
      n_hw++;
    end
    if (vsync && !prev_vs) begin
      if (last_vrise >= 0) begin
        check("lines_per_frame", hcount, LINES);
        check("vsync_period_clocks", k - last_vrise, FRAME);
      end
      hcount = 0;
      last_vrise = k;
      vrise = k;
    end
    if (!vsync && prev_vs) check("vsync_high_clocks", k - vrise, 6 * LINE);
    if (frame_tick && !prev_ft) begin
      if (last_ft < 0) check("first_frame_tick_clock", k, SNAP + 1);
      else check("frame_tick_period", k - last_ft, FRAME);
      last_ft = k;
    end
    prev_hs = hsync; prev_vs = vsync; prev_ft = frame_tick;
    // Change every input mid-frame (line 100 of frame 1); must not show until the next snapshot.
    if (phase == 1 && k == FRAME + 100 * LINE) drive_random();
    @(negedge clk);
    k++;
  endtask

  initial begin
    // Spot pixels: frame 0 shows reset shadows, frame 1 the test-A snapshot, frame 2 the random one.
    vecs.push_back('{0,   0, 575, C_CYAN,   "f0_paddle_left"});
    vecs.push_back('{0,  60, 575, C_CYAN,   "f0_paddle_right"});
    vecs.push_back('{0,  61, 575, C_BLACK,  "f0_paddle_past_end"});
    vecs.push_back('{0, 150,  45, C_BLACK,  "f0_brick_not_loaded"});
    vecs.push_back('{1, 150,  45, C_RED,    "brick9_red"});
    vecs.push_back('{1, 250,  45, C_YELLOW, "brick10_yellow"});
    vecs.push_back('{1, 100,  45, C_BLACK,  "brick_gap"});
    vecs.push_back('{1, 150, 300, C_BLACK,  "below_grid"});
    vecs.push_back('{1,  50,  15, C_RED,    "brick0_before_change"});
    vecs.push_back('{1,   0, 575, C_WHITE,  "ball_left_edge"});
    vecs.push_back('{1,   6, 575, C_WHITE,  "ball_right_edge"});
    vecs.push_back('{1,   7, 575, C_CYAN,   "paddle_after_ball"});
    vecs.push_back('{1,  91, 575, C_BLACK,  "paddle_end_clip"});
    vecs.push_back('{1,  59, 595, C_GREEN,  "score_last"});
    vecs.push_back('{1,  60, 595, C_BLACK,  "score_past"});
    vecs.push_back('{2,  50,  15, C_BLACK,  "brick0_after_snapshot"});

    phase = 0;
    drive_test_a();
    repeat (3) @(negedge clk);
    check("reset_hsync", int'(hsync), 0);
    check("reset_vsync", int'(vsync), 0);
    check("reset_rgb", int'({vga_r, vga_g, vga_b}), 0);
    check("reset_frame_tick", int'(frame_tick), 0);

    // Phase 0: run into line 300 and reset while hsync is high.
    begin_phase();
    rst = 1'b1;
    while (k < 300 * LINE + 900) step();
    check("hsync_before_midreset", int'(hsync), 1);
    rst = 1'b0;
    #1;
    check("midreset_hsync", int'(hsync), 0);
    check("midreset_vsync", int'(vsync), 0);
    check("midreset_rgb", int'({vga_r, vga_g, vga_b}), 0);
    check("midreset_frame_tick", int'(frame_tick), 0);
    repeat (2) @(negedge clk);

    // Phase 1: restart at (0,0), two snapshots, into the third frame.
    phase = 1;
    begin_phase();
    rst = 1'b1;
    while (k < 2 * FRAME + 31 * LINE) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
